// File: rtl/addr_map_pkg.sv
// Shared types for the programmable SNES->SRAM address window mapper:
// config field codes, flag bit positions, window record and commit states.
package addr_map_pkg;

    localparam int AMAP_ADDR_W = 24;
    localparam int FLAGS_W     = 5;

    typedef enum logic [1:0] {
        CFG_BASE   = 2'd0,
        CFG_MASK   = 2'd1,
        CFG_OFFSET = 2'd2,
        CFG_FLAGS  = 2'd3
    } cfg_field_e;

    localparam int FLAG_ENABLE     = 0;
    localparam int FLAG_WRITABLE   = 1;
    localparam int FLAG_SAVERAM    = 2;
    localparam int FLAG_ROMSEL_REQ = 3;
    localparam int FLAG_LOROM_FOLD = 4;

    typedef struct packed {
        logic [AMAP_ADDR_W-1:0] base;
        logic [AMAP_ADDR_W-1:0] cmp_mask;
        logic [AMAP_ADDR_W-1:0] offset;
        logic [FLAGS_W-1:0]     flags;
    } win_cfg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } commit_st_e;

    // LoROM images skip A15: bank bits slide down one place onto the 32 KiB page.
    function automatic logic [AMAP_ADDR_W-1:0] lorom_fold(input logic [AMAP_ADDR_W-1:0] a);
        return {1'b0, a[AMAP_ADDR_W-1:16], a[14:0]};
    endfunction

endpackage

// File: rtl/addr_map_window.sv
// One address window comparator: decides whether the SNES address falls in this
// window and returns the address with the compared bits stripped off.
module addr_map_window
    import addr_map_pkg::*;
(
    input  logic [AMAP_ADDR_W-1:0] base_i,
    input  logic [AMAP_ADDR_W-1:0] cmp_mask_i,
    input  logic                   enable_i,
    input  logic                   romsel_req_i,
    input  logic [AMAP_ADDR_W-1:0] snes_addr_i,
    input  logic                   snes_romsel_i,
    output logic                   match_o,
    output logic [AMAP_ADDR_W-1:0] local_o
);

    logic addr_hit;
    logic romsel_ok;

    assign addr_hit  = ((snes_addr_i ^ base_i) & cmp_mask_i) == '0;
    assign romsel_ok = !romsel_req_i || !snes_romsel_i;
    assign match_o   = enable_i && addr_hit && romsel_ok;
    assign local_o   = snes_addr_i & ~cmp_mask_i;

endmodule

// File: rtl/addr_window_map.sv
// Programmable SNES->SRAM address translator: NUM_WIN prioritised windows,
// double-buffered config that only goes live between SNES bus cycles.
module addr_window_map
    import addr_map_pkg::*;
#(
    parameter int NUM_WIN = 8,
    parameter int ADDR_W  = AMAP_ADDR_W,
    parameter int IDX_W   = $clog2(NUM_WIN)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] SNES_ADDR,
    input  logic              SNES_ROMSEL,
    input  logic              addr_valid,
    input  logic              snes_idle,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_win,
    input  logic [1:0]        cfg_field,
    input  logic [ADDR_W-1:0] cfg_data,
    input  logic              cfg_commit,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic              ROM_HIT,
    output logic              IS_SAVERAM,
    output logic              IS_WRITABLE,
    output logic [IDX_W-1:0]  hit_idx,
    output logic              out_valid,
    output logic              commit_pending
);

    win_cfg_t   shadow_q [NUM_WIN];
    win_cfg_t   shadow_d [NUM_WIN];
    win_cfg_t   active_q [NUM_WIN];
    commit_st_e state_q;
    commit_st_e state_d;
    logic       do_copy;

    logic [NUM_WIN-1:0] win_match;
    logic [ADDR_W-1:0]  win_local [NUM_WIN];

    logic               vld_p1_q;
    logic [NUM_WIN-1:0] match_p1_q;
    logic [ADDR_W-1:0]  local_p1_q [NUM_WIN];

    logic               hit_d;
    logic [IDX_W-1:0]   idx_d;
    win_cfg_t           win_sel;
    logic [ADDR_W-1:0]  local_sel;
    logic [ADDR_W-1:0]  rom_addr_d;
    logic               saveram_d;
    logic               writable_d;

    logic [ADDR_W-1:0]  rom_addr_q;
    logic               hit_q;
    logic               saveram_q;
    logic               writable_q;
    logic [IDX_W-1:0]   hit_idx_q;
    logic               out_valid_q;

    // Shadow write path; same-cycle writes are visible to a copy on that edge.
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we && (int'(cfg_win) < NUM_WIN)) begin
            case (cfg_field_e'(cfg_field))
                CFG_BASE:   shadow_d[cfg_win].base     = cfg_data;
                CFG_MASK:   shadow_d[cfg_win].cmp_mask = cfg_data;
                CFG_OFFSET: shadow_d[cfg_win].offset   = cfg_data;
                CFG_FLAGS:  shadow_d[cfg_win].flags    = cfg_data[FLAGS_W-1:0];
                default:    ;
            endcase
        end
    end

    // Copy waits for a quiet bus and an empty pipeline so no lookup straddles a remap.
    always_comb begin
        state_d = state_q;
        do_copy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_commit) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (snes_idle && !addr_valid && !vld_p1_q && !out_valid_q) begin
                    do_copy = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                shadow_q[w] <= '0;
                active_q[w] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            if (do_copy) begin
                active_q <= shadow_d;
            end
        end
    end

    for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
        addr_map_window u_win (
            .base_i        (active_q[w].base),
            .cmp_mask_i    (active_q[w].cmp_mask),
            .enable_i      (active_q[w].flags[FLAG_ENABLE]),
            .romsel_req_i  (active_q[w].flags[FLAG_ROMSEL_REQ]),
            .snes_addr_i   (SNES_ADDR),
            .snes_romsel_i (SNES_ROMSEL),
            .match_o       (win_match[w]),
            .local_o       (win_local[w])
        );
    end

    // Stage 1: per-window match vector and masked local addresses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p1_q   <= 1'b0;
            match_p1_q <= '0;
            for (int w = 0; w < NUM_WIN; w++) begin
                local_p1_q[w] <= '0;
            end
        end else begin
            vld_p1_q <= addr_valid;
            if (addr_valid) begin
                match_p1_q <= win_match;
                local_p1_q <= win_local;
            end
        end
    end

    // Stage 2: priority encode, fold and offset add. Active config is stable
    // here because a copy never happens with a lookup in flight.
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        for (int w = NUM_WIN - 1; w >= 0; w--) begin
            if (match_p1_q[w]) begin
                hit_d = 1'b1;
                idx_d = IDX_W'(w);
            end
        end
        win_sel   = active_q[idx_d];
        local_sel = local_p1_q[idx_d];
        if (win_sel.flags[FLAG_LOROM_FOLD]) begin
            local_sel = lorom_fold(local_sel);
        end
        rom_addr_d = '0;
        saveram_d  = 1'b0;
        writable_d = 1'b0;
        if (hit_d) begin
            rom_addr_d = win_sel.offset + local_sel;
            saveram_d  = win_sel.flags[FLAG_SAVERAM];
            writable_d = win_sel.flags[FLAG_WRITABLE] || win_sel.flags[FLAG_SAVERAM];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            rom_addr_q  <= '0;
            hit_q       <= 1'b0;
            saveram_q   <= 1'b0;
            writable_q  <= 1'b0;
            hit_idx_q   <= '0;
        end else begin
            out_valid_q <= vld_p1_q;
            if (vld_p1_q) begin
                rom_addr_q <= rom_addr_d;
                hit_q      <= hit_d;
                saveram_q  <= saveram_d;
                writable_q <= writable_d;
                hit_idx_q  <= hit_d ? idx_d : '0;
            end
        end
    end

    assign ROM_ADDR       = rom_addr_q;
    assign ROM_HIT        = hit_q;
    assign IS_SAVERAM     = saveram_q;
    assign IS_WRITABLE    = writable_q;
    assign hit_idx        = hit_idx_q;
    assign out_valid      = out_valid_q;
    assign commit_pending = (state_q == ST_PEND);

endmodule

// File: tb/tb_addr_window_map.sv
// Directed + randomized bench for addr_window_map against a table-driven window model.
module tb_addr_window_map;

    localparam int NW = 8;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [23:0] SNES_ADDR;
    logic        SNES_ROMSEL;
    logic        addr_valid;
    logic        snes_idle;
    logic        cfg_we;
    logic [2:0]  cfg_win;
    logic [1:0]  cfg_field;
    logic [23:0] cfg_data;
    logic        cfg_commit;
    logic [23:0] ROM_ADDR;
    logic        ROM_HIT;
    logic        IS_SAVERAM;
    logic        IS_WRITABLE;
    logic [2:0]  hit_idx;
    logic        out_valid;
    logic        commit_pending;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: [window][0=base,1=mask,2=offset,3=flags]
    int unsigned m_sh  [NW][4];
    int unsigned m_act [NW][4];

    addr_window_map dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .SNES_ADDR      (SNES_ADDR),
        .SNES_ROMSEL    (SNES_ROMSEL),
        .addr_valid     (addr_valid),
        .snes_idle      (snes_idle),
        .cfg_we         (cfg_we),
        .cfg_win        (cfg_win),
        .cfg_field      (cfg_field),
        .cfg_data       (cfg_data),
        .cfg_commit     (cfg_commit),
        .ROM_ADDR       (ROM_ADDR),
        .ROM_HIT        (ROM_HIT),
        .IS_SAVERAM     (IS_SAVERAM),
        .IS_WRITABLE    (IS_WRITABLE),
        .hit_idx        (hit_idx),
        .out_valid      (out_valid),
        .commit_pending (commit_pending)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int w = 0; w < NW; w++)
            for (int f = 0; f < 4; f++) begin
                m_sh[w][f]  = 0;
                m_act[w][f] = 0;
            end
    endfunction

    function automatic void model_commit();
        for (int w = 0; w < NW; w++)
            for (int f = 0; f < 4; f++) m_act[w][f] = m_sh[w][f];
    endfunction

    function automatic void model_lookup(input int unsigned a, input bit rs,
                                         output bit hit, output int unsigned idx,
                                         output int unsigned ra, output bit sv, output bit wr);
        hit = 0; idx = 0; ra = 0; sv = 0; wr = 0;
        for (int w = 0; w < NW; w++) begin
            int unsigned f;
            int unsigned loc;
            f = m_act[w][3];
            if (!hit && f[0] && (((a ^ m_act[w][0]) & m_act[w][1] & 32'hFFFFFF) == 0)
                && (!f[3] || !rs)) begin
                loc = a & ~m_act[w][1] & 32'hFFFFFF;
                if (f[4]) loc = (loc >> 16) * 32768 + (loc & 32'h7FFF);
                hit = 1;
                idx = w;
                ra  = (m_act[w][2] + loc) & 32'hFFFFFF;
                sv  = f[2];
                wr  = f[1] | f[2];
            end
        end
    endfunction

    task automatic check_result(input string tag, input logic [23:0] a, input bit r);
        bit hit, sv, wr;
        int unsigned idx, ra;
        model_lookup(a, r, hit, idx, ra, sv, wr);
        check({tag, "_vld"},  out_valid, 1);
        check({tag, "_hit"},  ROM_HIT, hit);
        check({tag, "_idx"},  hit_idx, idx);
        check({tag, "_addr"}, ROM_ADDR, ra);
        check({tag, "_sv"},   IS_SAVERAM, sv);
        check({tag, "_wr"},   IS_WRITABLE, wr);
    endtask

    task automatic lookup(input string tag, input logic [23:0] a, input bit r);
        SNES_ADDR = a; SNES_ROMSEL = r; addr_valid = 1;
        @(posedge CLK); #1;
        addr_valid = 0;
        check({tag, "_early"}, out_valid, 0);
        @(posedge CLK); #1;
        check_result(tag, a, r);
        @(posedge CLK); #1;
        check({tag, "_pulse"}, out_valid, 0);
    endtask

    task automatic cfg_write(input int w, input int f, input logic [23:0] d, input bit commit);
        cfg_we = 1; cfg_win = 3'(w); cfg_field = 2'(f); cfg_data = d; cfg_commit = commit;
        @(posedge CLK); #1;
        cfg_we = 0; cfg_commit = 0;
        m_sh[w][f] = d;
    endtask

    task automatic write_win(input int w, input logic [23:0] b, input logic [23:0] m,
                             input logic [23:0] o, input logic [23:0] fl);
        cfg_write(w, 0, b, 0);
        cfg_write(w, 1, m, 0);
        cfg_write(w, 2, o, 0);
        cfg_write(w, 3, fl, 0);
    endtask

    task automatic do_commit(input string tag);
        cfg_commit = 1;
        @(posedge CLK); #1;
        cfg_commit = 0;
        check({tag, "_pend_rise"}, commit_pending, 1);
        @(posedge CLK); #1;
        check({tag, "_pend_fall"}, commit_pending, 0);
        model_commit();
    endtask

    function automatic logic [23:0] gen_addr(input int mode);
        int w;
        if (mode == 1) begin
            w = $urandom_range(0, NW - 1);
            return 24'((m_act[w][0] ^ ($urandom & ~m_act[w][1])) & 32'hFFFFFF);
        end else if (mode == 2) begin
            return 24'h400000 | 24'($urandom & 32'h3FFFFF);
        end
        return 24'($urandom & 32'hFFFFFF);
    endfunction

    task automatic run_stream(input string tag, input int n, input int mode, input bit chk_pend);
        logic [23:0] addrs [$];
        bit          rss   [$];
        for (int j = 0; j <= n; j++) begin
            if (j < n) begin
                logic [23:0] a;
                bit r;
                a = gen_addr(mode);
                r = 1'($urandom_range(0, 1));
                addrs.push_back(a);
                rss.push_back(r);
                SNES_ADDR = a; SNES_ROMSEL = r; addr_valid = 1;
            end else begin
                addr_valid = 0;
            end
            @(posedge CLK); #1;
            if (chk_pend) check({tag, "_pend"}, commit_pending, 1);
            if (j >= 1) check_result(tag, addrs[j-1], rss[j-1]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, ROM_ADDR, 0);
        check({tag, "_hit"},  ROM_HIT, 0);
        check({tag, "_sv"},   IS_SAVERAM, 0);
        check({tag, "_wr"},   IS_WRITABLE, 0);
        check({tag, "_idx"},  hit_idx, 0);
        check({tag, "_vld"},  out_valid, 0);
        check({tag, "_pend"}, commit_pending, 0);
    endtask

    initial begin
        RST_N = 0; SNES_ADDR = 0; SNES_ROMSEL = 1; addr_valid = 0; snes_idle = 1;
        cfg_we = 0; cfg_win = 0; cfg_field = 0; cfg_data = 0; cfg_commit = 0;
        model_clear();
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("rst");
        RST_N = 1;
        @(posedge CLK); #1;

        lookup("rst_lk", 24'h008000, 1);
        check("rst_lk_miss", ROM_HIT, 0);
        check("rst_lk_zero", ROM_ADDR, 0);

        write_win(0, 24'h008000, 24'h408000, 24'h000000, 24'h11);
        do_commit("lorom");
        lookup("lorom", 24'h018123, 1);
        check("lorom_const_addr", ROM_ADDR, 24'h008123);
        check("lorom_const_idx", hit_idx, 0);
        check("lorom_const_hit", ROM_HIT, 1);

        write_win(0, 24'h700000, 24'hF08000, 24'hE00000, 24'h0F);
        write_win(1, 24'h400000, 24'hC00000, 24'h000000, 24'h01);
        do_commit("prio");
        lookup("prio_rs0", 24'h701234, 0);
        check("prio_rs0_idx", hit_idx, 0);
        check("prio_rs0_addr", ROM_ADDR, 24'hE01234);
        check("prio_rs0_sv", IS_SAVERAM, 1);
        check("prio_rs0_wr", IS_WRITABLE, 1);
        lookup("prio_rs1", 24'h701234, 1);
        check("prio_rs1_idx", hit_idx, 1);

        // New map staged in shadow; commit held off by a busy bus.
        cfg_write(1, 2, 24'h100000, 0);
        write_win(2, 24'hC00000, 24'hFF0000, 24'h200000, 24'h03);
        snes_idle = 0;
        cfg_commit = 1;
        @(posedge CLK); #1;
        cfg_commit = 0;
        check("defer_pend_rise", commit_pending, 1);
        run_stream("defer_old", 5, 2, 1);
        snes_idle = 1;
        @(posedge CLK); #1;
        check("defer_drain_pend", commit_pending, 1);
        @(posedge CLK); #1;
        check("defer_pend_fall", commit_pending, 0);
        model_commit();
        lookup("defer_new", 24'h412345, 1);
        check("defer_new_addr", ROM_ADDR, 24'h112345);
        lookup("defer_new2", 24'hC0ABCD, 1);

        write_win(3, 24'h800000, 24'hFFFF00, 24'h000000, 24'h01);
        cfg_write(3, 2, 24'hFFFFF0, 1);
        check("wrap_pend_rise", commit_pending, 1);
        @(posedge CLK); #1;
        check("wrap_pend_fall", commit_pending, 0);
        model_commit();
        lookup("wrap", 24'h800020, 1);
        check("wrap_const_addr", ROM_ADDR, 24'h000010);
        check("wrap_const_idx", hit_idx, 3);

        for (int w = 4; w < NW; w++) begin
            write_win(w, 24'($urandom), 24'(($urandom & 32'hFF0000) | ($urandom & 32'h8000)),
                      24'($urandom), 24'(($urandom & 32'h1F) | 32'h1));
        end
        do_commit("rnd");
        run_stream("rnd_near", 24, 1, 0);
        @(posedge CLK); #1;
        run_stream("rnd_any", 16, 0, 0);
        @(posedge CLK); #1;

        // Reset lands between addr_valid and out_valid, with a commit pending.
        snes_idle = 0;
        SNES_ADDR = 24'h701234; SNES_ROMSEL = 0; addr_valid = 1; cfg_commit = 1;
        @(posedge CLK); #1;
        addr_valid = 0; cfg_commit = 0;
        RST_N = 0;
        model_clear();
        #1;
        check_all_zero("mid_rst");
        @(posedge CLK); #1;
        check("mid_rst_vld1", out_valid, 0);
        @(posedge CLK); #1;
        check("mid_rst_vld2", out_valid, 0);
        RST_N = 1; snes_idle = 1;
        @(posedge CLK); #1;
        lookup("post_rst", 24'h701234, 0);
        check("post_rst_miss", ROM_HIT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
